// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling from a runtime
// baud divisor, and a one-deep valid/ready holding register with overrun/framing flags.
module uart_rx #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic [DIV_W-1:0]  i_div,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e              state_q;
  logic                sync_q;
  logic                rx_s_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [DIV_W-1:0]    div_q;
  logic [BW-1:0]       bit_q;
  logic [DATA_W-1:0]   shift_q;

  logic                tick;
  logic                accept;
  logic [DIV_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   shift_d;

  assign tick    = (cnt_q == '0);
  assign accept  = o_valid && i_ready;
  assign cnt_d   = tick ? div_q : cnt_q - 1'b1;
  assign shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
  assign o_busy  = (state_q != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      sync_q      <= i_rx;
      rx_s_q      <= sync_q;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      cnt_q       <= cnt_d;
      if (accept) o_valid <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Divisor is frozen here so mid-frame register writes cannot skew sampling.
          if (!rx_s_q) begin
            div_q   <= i_div;
            cnt_q   <= i_div >> 1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              bit_q   <= '0;
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= shift_d;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s_q) begin
              // Back to IDLE mid stop bit so a following start edge is not missed.
              state_q <= S_IDLE;
              if (!o_valid || accept) begin
                o_data  <= shift_q;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-timed 8N1 frames, a negedge monitor that
// counts flag pulses and valid rises, and one checking task for all comparisons.
module tb_uart_rx;

  logic        i_clk;
  logic        i_rst;
  logic        i_rx;
  logic [15:0] i_div;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_frame_err;
  logic        o_overrun;
  logic        o_busy;

  uart_rx #(.DIV_W(16), .DATA_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_div       (i_div),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // monitor: sole writer of the event counters
  int         n_ferr = 0, n_ovr = 0, n_vrise = 0, n_vhigh = 0, n_busy = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = '0;
  logic       prev_v = 1'b0;

  always @(negedge i_clk) begin
    if (o_frame_err) n_ferr++;
    if (o_overrun) n_ovr++;
    if (o_valid && !prev_v) begin
      n_vrise++;
      rise_cyc  = cyc;
      rise_data = o_data;
    end
    if (o_valid) n_vhigh++;
    if (o_busy) n_busy++;
    prev_v = o_valid;
  end

  int n_chk = 0, n_err = 0;
  int b_ferr, b_ovr, b_vrise, b_vhigh, b_busy;
  int start_cyc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    b_ferr  = n_ferr;
    b_ovr   = n_ovr;
    b_vrise = n_vrise;
    b_vhigh = n_vhigh;
    b_busy  = n_busy;
  endtask

  // Drive n_e clock edges of a frame (bit 0 start, 1..8 data LSB first, 9 stop).
  // rdy_e >= 0 raises i_ready for exactly the cycle before edge rdy_e.
  task automatic send_frame(input logic [7:0] b, input logic stp, input int bl,
                            input int rdy_e, input int n_e);
    start_cyc = cyc + 1;
    for (int e = 0; e < n_e; e++) begin
      int bi;
      bi = e / bl;
      if (bi == 0)      i_rx = 1'b0;
      else if (bi <= 8) i_rx = b[bi-1];
      else              i_rx = stp;
      if (rdy_e >= 0) begin
        if (e == rdy_e)          i_ready = 1'b1;
        else if (e == rdy_e + 1) i_ready = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b0;
    i_div   = 16'd9;
    repeat (3) tick();
    chk("rst_data",  32'(o_data), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ferr",  32'(o_frame_err), 0);
    chk("rst_ovr",   32'(o_overrun), 0);
    chk("rst_busy",  32'(o_busy), 0);
    i_rst = 1'b0;
    repeat (3) tick();

    // single byte, consumer always ready
    i_ready = 1'b1;
    clr();
    send_frame(8'hA5, 1'b1, 10, -1, 100);
    repeat (5) tick();
    chk("t1_rises",   n_vrise - b_vrise, 1);
    chk("t1_latency", rise_cyc - start_cyc, 97);
    chk("t1_data",    32'(rise_data), 'hA5);
    chk("t1_vhigh",   n_vhigh - b_vhigh, 1);
    chk("t1_ferr",    n_ferr - b_ferr, 0);
    chk("t1_ovr",     n_ovr - b_ovr, 0);

    // overrun: second byte dropped, first held
    i_ready = 1'b0;
    clr();
    send_frame(8'h3C, 1'b1, 10, -1, 100);
    send_frame(8'hC3, 1'b1, 10, -1, 100);
    repeat (5) tick();
    chk("t2_rises", n_vrise - b_vrise, 1);
    chk("t2_ovr",   n_ovr - b_ovr, 1);
    chk("t2_ferr",  n_ferr - b_ferr, 0);
    chk("t2_valid", 32'(o_valid), 1);
    chk("t2_data",  32'(o_data), 'h3C);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("t2_drain", 32'(o_valid), 0);

    // accept and deliver on the same edge
    clr();
    send_frame(8'h55, 1'b1, 10, -1, 100);
    send_frame(8'h81, 1'b1, 10, 97, 100);
    repeat (5) tick();
    chk("t3_first", 32'(rise_data), 'h55);
    chk("t3_rises", n_vrise - b_vrise, 1);
    chk("t3_data",  32'(o_data), 'h81);
    chk("t3_valid", 32'(o_valid), 1);
    chk("t3_ovr",   n_ovr - b_ovr, 0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("t3_drain", 32'(o_valid), 0);

    // framing error then held-low break
    i_div   = 16'd15;
    i_ready = 1'b1;
    clr();
    send_frame(8'hFF, 1'b0, 16, -1, 160);
    repeat (40) tick();
    chk("t4_ferr",  n_ferr - b_ferr, 1);
    chk("t4_rises", n_vrise - b_vrise, 0);
    chk("t4_busy",  32'(o_busy), 1);
    i_rx = 1'b1;
    tick();
    tick();
    chk("t4_busy_hold", 32'(o_busy), 1);
    tick();
    chk("t4_idle", 32'(o_busy), 0);

    // false start
    i_div   = 16'd9;
    i_ready = 1'b0;
    clr();
    i_rx = 1'b0;
    repeat (3) tick();
    i_rx = 1'b1;
    repeat (20) tick();
    chk("t5_busy_cycles", n_busy - b_busy, 5);
    chk("t5_idle",  32'(o_busy), 0);
    chk("t5_rises", n_vrise - b_vrise, 0);
    chk("t5_ferr",  n_ferr - b_ferr, 0);

    // reset mid frame, with a byte pending so the reset has something to clear
    send_frame(8'h3C, 1'b1, 10, -1, 100);
    chk("t6_pre_valid", 32'(o_valid), 1);
    send_frame(8'h5A, 1'b1, 10, -1, 50);
    chk("t6_pre_busy", 32'(o_busy), 1);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    tick();
    chk("t6_rst_data",  32'(o_data), 0);
    chk("t6_rst_valid", 32'(o_valid), 0);
    chk("t6_rst_busy",  32'(o_busy), 0);
    chk("t6_rst_ferr",  32'(o_frame_err), 0);
    chk("t6_rst_ovr",   32'(o_overrun), 0);
    i_rst = 1'b0;
    repeat (5) tick();
    clr();
    send_frame(8'h96, 1'b1, 10, -1, 100);
    repeat (5) tick();
    chk("t6_rises", n_vrise - b_vrise, 1);
    chk("t6_data",  32'(o_data), 'h96);
    chk("t6_valid", 32'(o_valid), 1);
    chk("t6_ferr",  n_ferr - b_ferr, 0);
    chk("t6_ovr",   n_ovr - b_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end inside SOC_TOP, directly downstream of the i_io_rx / i_io_rx2 pins.
- Converts the asynchronous 8N1 line into bytes, delivered over a valid/ready handshake to the UART peripheral register/FIFO logic.
- One instance per receive pin; the runtime baud divisor comes from the peripheral's control register.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- DATA_W, 8, data bits per frame. Fixed 8; other values are unsupported.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous reset, active-high
- i_rx  input  1  raw asynchronous serial line; idle level is 1
- i_div  input  DIV_W  clocks per bit minus 1. Legal range is 3 or more. It is captured at start-bit detection.
- o_data  output  8  received byte; stable while o_valid=1
- o_valid  output  1  byte available
- i_ready  input  1  consumer accepts; transfer occurs on o_valid&&i_ready
- o_frame_err  output  1  one-cycle pulse: stop bit sampled 0
- o_overrun  output  1  one-cycle pulse: byte dropped because the holding register was full
- o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Synchronizer flops=1, FSM=IDLE, bit counter=0.
- Reset mid-frame aborts the frame with no error pulse.
- Synchronizer:
  - i_rx passes through 2 flops to give rx_s; only rx_s is used.
  - Latency from i_rx to rx_s is 2 cycles.
- Baud counter cnt (DIV_W bits) decrements each cycle. When cnt==0 the FSM samples rx_s and reloads cnt with div_q (the latched i_div).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, latch div_q=i_div, set cnt=i_div>>1, go to START. This cycle is "detection".
  - START: at cnt==0 sample rx_s.
    - 1 → false start, go to IDLE, no pulse.
    - 0 → go to DATA, bit index=0.
  - DATA: at each cnt==0, shift rx_s in LSB-first. After the 8th sample go to STOP.
  - STOP: at cnt==0 sample rx_s.
    - 1 → deliver the byte, go to IDLE. IDLE is entered mid stop bit, so back-to-back frames are accepted.
    - 0 → o_frame_err pulse next cycle, byte discarded, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Prevents a held-low line from retriggering.
- Sample timing (cycles after detection):
  - Start-bit sample at (i_div>>1).
  - Data bit k sample at (i_div>>1)+(k+1)(i_div+1).
  - Stop sample at (i_div>>1)+9(i_div+1).
- Delivery happens at the stop sample; its effect is registered and visible the next cycle.
  - If o_valid==0, or o_valid&&i_ready in the same cycle: o_data←byte, o_valid←1.
  - Otherwise: o_valid stays 1, old o_data is kept, the new byte is dropped, and o_overrun pulses 1 cycle.
- Handshake:
  - o_valid falls the cycle after o_valid&&i_ready, unless a simultaneous delivery reloads it.
  - o_data must not change while o_valid=1 except on that simultaneous accept+deliver.
- i_div changes mid-frame have no effect until the next detection.
- Behaviour with i_div<3 is unspecified.
- o_busy = (state != IDLE).

Test Plan:
- i_div=9, i_ready=1, drive 0xA5 8N1 at 10 clk/bit → o_data=0xA5 and o_valid rises exactly 97 clocks after i_rx is first sampled low. It stays high 1 cycle. No error pulses.
- i_div=9, i_ready=0, send 0x3C then 0xC3 back-to-back → first byte 0x3C held with o_valid=1. o_overrun pulses once at the second stop. Raising i_ready yields 0x3C, after which o_valid=0.
- i_div=9, i_ready=0, send 0x55 then 0x81. Assert i_ready for exactly the cycle the second stop sample occurs → o_data=0x81, o_valid stays 1, no overrun.
- i_div=15, send 0xFF with the stop bit driven 0, then hold the line low 40 clocks → one o_frame_err pulse, o_valid stays 0. The FSM stays in BREAK (o_busy=1) until the line returns high, then goes to IDLE.
- i_div=9, pulse i_rx low for 3 clocks → false start: o_busy returns to 0 after 5 cycles in START, no output, no pulses.
- Assert i_rst during DATA of a 0x5A frame → all outputs 0 the next cycle. A following clean 0x96 frame is received correctly.
